uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit packet stream between NUM_SOURCES packet producers, e.g. register read-response and status/telemetry generators.
- Arbitration is round-robin at packet granularity: once a source is granted, it owns the stream from its SoP beat through its EoP beat.
- Sits between the producers and the UART packet transmitter.
- Uses valid/ready handshake on both sides, with a registered output stage.

---
 rtl/uart_tx_arbiter_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr_priority_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit-side packet arbiter: the producer/transmitter
// packet beat and the arbiter state encoding.
package uart_tx_arbiter_pkg;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Data;
        logic       SoP;
        logic       EoP;
        logic       Valid;
    } UART_PACKET;

    typedef enum logic {
        IDLE,
        PACKET
    } ArbState;

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: returns the first requester found searching
// upward from pointer+1 with wrap-around.
module rr_priority_picker #(
    parameter int NUM_SOURCES = 2
) (
    input  logic [NUM_SOURCES-1:0]         ipRequest,
    input  logic [$clog2(NUM_SOURCES)-1:0] ipPointer,
    output logic                           opFound,
    output logic [$clog2(NUM_SOURCES)-1:0] opIndex
);

    localparam int IW = $clog2(NUM_SOURCES);

    logic [IW-1:0] candidate;

    // Walk from the farthest position back to pointer+1 so the nearest hit wins.
    always_comb begin
        opFound   = 1'b0;
        opIndex   = '0;
        candidate = '0;
        for (int i = NUM_SOURCES; i >= 1; i--) begin
            candidate = IW'((int'(ipPointer) + i) % NUM_SOURCES);
            if (ipRequest[candidate]) begin
                opFound = 1'b1;
                opIndex = candidate;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmit stream between
// NUM_SOURCES producers, with a registered output stage and idle-owner timeout.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_SOURCES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   ipClk,
    input  logic                   ipReset,
    input  UART_PACKET             ipStreams [NUM_SOURCES],
    output logic [NUM_SOURCES-1:0] opReady,
    output UART_PACKET             opTxStream,
    input  logic                   ipTxReady,
    output logic [NUM_SOURCES-1:0] opGrant,
    output logic                   opTimeout
);

    localparam int IW = $clog2(NUM_SOURCES);
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    ArbState                state, stateNext;
    logic [IW-1:0]          pointer, pointerNext;
    logic [NUM_SOURCES-1:0] grantNext;
    logic [CW-1:0]          idleCnt, idleCntNext;
    logic                   timeoutNext;
    UART_PACKET             txNext;
    UART_PACKET             ownerBeat;
    logic                   txFree;
    logic [NUM_SOURCES-1:0] sopReq, junkReq;
    logic                   pickFound;
    logic [IW-1:0]          pickIndex;
    logic                   resetQ;
    logic                   rst;

    // The registered copy stretches reset by one cycle; ipReset itself still
    // takes effect on the very next edge so a mid-packet reset drops at once.
    always_ff @(posedge ipClk) begin
        resetQ <= ipReset;
    end
    assign rst = ipReset | resetQ;

    always_comb begin
        sopReq  = '0;
        junkReq = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            sopReq[i]  = ipStreams[i].Valid && ipStreams[i].SoP;
            junkReq[i] = ipStreams[i].Valid && !ipStreams[i].SoP;
        end
    end

    rr_priority_picker #(
        .NUM_SOURCES(NUM_SOURCES)
    ) uPicker (
        .ipRequest(sopReq),
        .ipPointer(pointer),
        .opFound  (pickFound),
        .opIndex  (pickIndex)
    );

    // In PACKET the pointer doubles as the owner index.
    assign ownerBeat = ipStreams[pointer];
    assign txFree    = !opTxStream.Valid || ipTxReady;

    always_comb begin
        stateNext   = state;
        pointerNext = pointer;
        grantNext   = opGrant;
        idleCntNext = idleCnt;
        timeoutNext = 1'b0;
        txNext      = opTxStream;
        opReady     = '0;
        if (ipTxReady) begin
            txNext.Valid = 1'b0;
        end
        case (state)
            IDLE: begin
                // Beats without SoP are drained here so producers resync on SoP.
                opReady = junkReq;
                if (pickFound) begin
                    stateNext            = PACKET;
                    pointerNext          = pickIndex;
                    grantNext            = '0;
                    grantNext[pickIndex] = 1'b1;
                    idleCntNext          = '0;
                end
            end
            PACKET: begin
                opReady[pointer] = txFree;
                if (ownerBeat.Valid && txFree) begin
                    txNext      = ownerBeat;
                    idleCntNext = '0;
                    if (ownerBeat.EoP) begin
                        stateNext = IDLE;
                        grantNext = '0;
                    end
                end else if (!ownerBeat.Valid && TIMEOUT_CYCLES != 0) begin
                    if (idleCnt == TIMEOUT_LAST) begin
                        stateNext   = IDLE;
                        grantNext   = '0;
                        timeoutNext = 1'b1;
                        idleCntNext = '0;
                    end else begin
                        idleCntNext = idleCnt + CW'(1);
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                grantNext = '0;
            end
        endcase
    end

    always_ff @(posedge ipClk) begin
        if (rst) begin
            state      <= IDLE;
            pointer    <= IW'(NUM_SOURCES - 1);
            opGrant    <= '0;
            idleCnt    <= '0;
            opTimeout  <= 1'b0;
            opTxStream <= '0;
        end else begin
            state      <= stateNext;
            pointer    <= pointerNext;
            opGrant    <= grantNext;
            idleCnt    <= idleCntNext;
            opTimeout  <= timeoutNext;
            opTxStream <= txNext;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-source expected-beat queues filled at
// stimulus time, drained by an output monitor; directed scenarios plus random traffic.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int NS = 2;
    localparam int TO = 8;

    logic           ipClk = 1'b0;
    logic           ipReset = 1'b1;
    logic           ipTxReady = 1'b1;
    UART_PACKET     streams [NS];
    logic [NS-1:0]  opReady;
    logic [NS-1:0]  opGrant;
    UART_PACKET     opTxStream;
    logic           opTimeout;

    uart_tx_arbiter #(
        .NUM_SOURCES   (NS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .ipClk     (ipClk),
        .ipReset   (ipReset),
        .ipStreams (streams),
        .opReady   (opReady),
        .opTxStream(opTxStream),
        .ipTxReady (ipTxReady),
        .opGrant   (opGrant),
        .opTimeout (opTimeout)
    );

    always #5 ipClk = ~ipClk;

    typedef struct {
        UART_PACKET beat;
        bit         junk;
    } StimBeat;

    StimBeat    stimQ [NS][$];
    UART_PACKET expQ  [NS][$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         maxGap = 0;
    int         txMode = 0;
    int         txIdx = 0;
    bit         txPat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit         flushReq = 1'b0;
    int         xferCount [NS];
    int         lastXferEdge [NS];
    int         sopCyc [NS];
    int         gap [NS];
    bit         chkPend [NS];
    UART_PACKET chkBeat [NS];
    bit         drvXfer [NS];
    bit         drvFresh;
    int         grantLog [$];
    int         grantEdge = 0;
    int         timeoutCount = 0;
    int         timeoutEdge = 0;
    int         curSrc = -1;
    int         monSrc;
    logic [NS-1:0] prevGrant = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic int oneHotIdx(input logic [NS-1:0] v);
        int r = -1;
        for (int i = 0; i < NS; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic int grantSeq();
        int s = 0;
        foreach (grantLog[k]) s = s * 10 + grantLog[k] + 1;
        return s;
    endfunction

    function automatic bit allDrained();
        bit d = !opTxStream.Valid && (opGrant == '0);
        for (int i = 0; i < NS; i++) d = d && (stimQ[i].size() == 0) && (expQ[i].size() == 0);
        return d;
    endfunction

    task automatic sendPacket(input int src, input int len, input logic [7:0] base, input bit noEop);
        StimBeat st;
        for (int j = 0; j < len; j++) begin
            st.beat.Source = 8'(src + 1);
            st.beat.Data   = base + 8'(j);
            st.beat.SoP    = (j == 0);
            st.beat.EoP    = (j == len - 1) && !noEop;
            st.beat.Valid  = 1'b1;
            st.junk        = 1'b0;
            stimQ[src].push_back(st);
            expQ[src].push_back(st.beat);
        end
    endtask

    task automatic sendJunk(input int src, input int n);
        StimBeat st;
        for (int j = 0; j < n; j++) begin
            st.beat.Source = 8'(src + 1);
            st.beat.Data   = 8'hEE;
            st.beat.SoP    = 1'b0;
            st.beat.EoP    = 1'($urandom_range(0, 1));
            st.beat.Valid  = 1'b1;
            st.junk        = 1'b1;
            stimQ[src].push_back(st);
        end
    endtask

    task automatic waitIdle(input string name, input int budget);
        int k = 0;
        while (k < budget && !allDrained()) begin
            @(posedge ipClk);
            #2;
            k++;
        end
        check({name, " drained"}, 64'(allDrained()), 64'd1);
    endtask

    always @(posedge ipClk) cyc <= cyc + 1;

    // Producer model: presents queued beats with random gaps, holds until accepted.
    initial begin
        for (int i = 0; i < NS; i++) begin
            streams[i] = '0;
            xferCount[i] = 0;
            gap[i] = 0;
            chkPend[i] = 1'b0;
            sopCyc[i] = 0;
            lastXferEdge[i] = 0;
        end
        forever begin
            @(negedge ipClk);
            for (int i = 0; i < NS; i++) begin
                if (chkPend[i]) begin
                    check($sformatf("latency src%0d", i), 64'(opTxStream), 64'(chkBeat[i]));
                    chkPend[i] = 1'b0;
                end
                drvXfer[i] = !ipReset && streams[i].Valid && opReady[i];
            end
            @(posedge ipClk);
            #1;
            if (flushReq) begin
                for (int i = 0; i < NS; i++) begin
                    stimQ[i].delete();
                    streams[i] = '0;
                    chkPend[i] = 1'b0;
                    drvXfer[i] = 1'b0;
                end
                flushReq = 1'b0;
            end else begin
                for (int i = 0; i < NS; i++) begin
                    drvFresh = drvXfer[i] || !streams[i].Valid;
                    if (drvXfer[i]) begin
                        xferCount[i]++;
                        lastXferEdge[i] = cyc;
                        chkPend[i] = !stimQ[i][0].junk;
                        chkBeat[i] = stimQ[i][0].beat;
                        void'(stimQ[i].pop_front());
                        gap[i] = int'($urandom_range(0, maxGap));
                    end
                    if (stimQ[i].size() == 0) begin
                        streams[i] = '0;
                    end else if (drvFresh && gap[i] > 0) begin
                        gap[i]--;
                        streams[i] = '0;
                    end else begin
                        if (drvFresh && stimQ[i][0].beat.SoP) sopCyc[i] = cyc;
                        streams[i] = stimQ[i][0].beat;
                    end
                end
            end
            case (txMode)
                0: ipTxReady = 1'b1;
                1: ipTxReady = 1'($urandom_range(0, 1));
                default: begin
                    ipTxReady = txPat[txIdx % 4];
                    txIdx++;
                end
            endcase
        end
    end

    // Output monitor: scoreboard compare, contiguity, ready rule, grant and timeout log.
    always @(negedge ipClk) begin
        if (!ipReset) begin
            if (opTxStream.Valid && ipTxReady) begin
                monSrc = int'(opTxStream.Source) - 1;
                if (monSrc < 0 || monSrc >= NS || expQ[monSrc].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %0h, required no beat", opTxStream);
                end else begin
                    check("output beat", 64'(opTxStream), 64'(expQ[monSrc].pop_front()));
                    if (opTxStream.SoP) curSrc = monSrc;
                    else check("contiguity", 64'(monSrc), 64'(curSrc));
                end
            end
            if (opGrant != '0) begin
                check("grant onehot", 64'($countones(opGrant)), 64'd1);
                check("ready rule", 64'(opReady),
                      64'((opTxStream.Valid && !ipTxReady) ? {NS{1'b0}} : opGrant));
                if (prevGrant == '0) begin
                    grantLog.push_back(oneHotIdx(opGrant));
                    grantEdge = cyc;
                end
            end
            if (opTimeout) begin
                timeoutCount++;
                timeoutEdge = cyc;
            end
        end
        prevGrant = opGrant;
    end

    initial begin
        int k;
        int base;
        int t0;
        repeat (3) @(posedge ipClk);
        @(negedge ipClk);
        check("reset txstream", 64'(opTxStream), 64'd0);
        check("reset ready", 64'(opReady), 64'd0);
        check("reset grant", 64'(opGrant), 64'd0);
        check("reset timeout", 64'(opTimeout), 64'd0);
        @(posedge ipClk);
        #2;
        ipReset = 1'b0;

        // Round-robin from reset: both sources hold two 3-beat packets.
        maxGap = 0;
        txMode = 0;
        grantLog.delete();
        sendPacket(0, 3, 8'h10, 1'b0);
        sendPacket(0, 3, 8'h20, 1'b0);
        sendPacket(1, 3, 8'h30, 1'b0);
        sendPacket(1, 3, 8'h40, 1'b0);
        waitIdle("round robin", 300);
        check("rr order", 64'(grantSeq()), 64'd1212);

        // Single 5-beat packet from source 1.
        grantLog.delete();
        sendPacket(1, 5, 8'hA0, 1'b0);
        waitIdle("single", 200);
        check("single grant", 64'(grantSeq()), 64'd2);
        check("single grant timing", 64'(grantEdge), 64'(sopCyc[1] + 1));

        // Backpressure pattern 1,0,0,1 on a 4-beat packet.
        txMode = 2;
        txIdx = 0;
        sendPacket(0, 4, 8'h50, 1'b0);
        waitIdle("backpressure", 200);
        txMode = 0;

        // Junk beats before SoP are swallowed.
        base = xferCount[0];
        sendJunk(0, 3);
        sendPacket(0, 3, 8'h60, 1'b0);
        waitIdle("junk", 200);
        check("junk consumed", 64'(xferCount[0] - base), 64'd6);

        // Timeout: source 0 stalls after two beats while source 1 waits.
        check("no spurious timeout", 64'(timeoutCount), 64'd0);
        t0 = timeoutCount;
        grantLog.delete();
        sendPacket(0, 2, 8'h70, 1'b1);
        k = 0;
        while (k < 50 && grantLog.size() == 0) begin
            @(posedge ipClk);
            #2;
            k++;
        end
        check("timeout first grant", 64'(grantSeq()), 64'd1);
        sendPacket(1, 2, 8'h80, 1'b0);
        waitIdle("timeout", 300);
        check("timeout pulses", 64'(timeoutCount - t0), 64'd1);
        check("timeout delay", 64'(timeoutEdge - lastXferEdge[0]), 64'(TO));
        check("grant after timeout", 64'(grantSeq()), 64'd12);

        // Reset asserted once beat 2 of 4 has transferred.
        base = xferCount[0];
        sendPacket(0, 4, 8'h90, 1'b0);
        k = 0;
        while (k < 100 && xferCount[0] < base + 2) begin
            @(posedge ipClk);
            #2;
            k++;
        end
        check("reached beat 2", 64'(xferCount[0] - base), 64'd2);
        ipReset = 1'b1;
        flushReq = 1'b1;
        @(posedge ipClk);
        #2;
        for (int i = 0; i < NS; i++) expQ[i].delete();
        curSrc = -1;
        @(negedge ipClk);
        check("midreset valid", 64'(opTxStream.Valid), 64'd0);
        check("midreset grant", 64'(opGrant), 64'd0);
        check("midreset ready", 64'(opReady), 64'd0);
        @(posedge ipClk);
        #2;
        ipReset = 1'b0;
        grantLog.delete();
        sendPacket(1, 2, 8'hB0, 1'b0);
        sendPacket(0, 2, 8'hC0, 1'b0);
        waitIdle("after reset", 200);
        check("priority after reset", 64'(grantSeq()), 64'd12);

        // Random traffic with gaps, junk and random transmitter backpressure.
        maxGap = 3;
        txMode = 1;
        grantLog.delete();
        for (int p = 0; p < 6; p++) begin
            for (int s = 0; s < NS; s++) begin
                if ($urandom_range(0, 4) == 0) sendJunk(s, int'($urandom_range(1, 2)));
                sendPacket(s, int'($urandom_range(1, 5)), 8'($urandom), 1'b0);
            end
        end
        waitIdle("random", 4000);
        check("random grants", 64'(grantLog.size()), 64'd12);
        check("random no timeout", 64'(timeoutCount - t0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
